// File: rtl/reg_file_8x16_pkg.sv
// Shared widths, types and reset value for the register file and its neighbours.
// No logic of its own; bus_mux2 is the datapath's 2:1 16-bit bus multiplexer.
// Buses are MSB-first ([0:W-1]) to match the rest of the datapath.
package reg_file_8x16_pkg;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = 3;

  typedef logic [0:W-1]  word_t;
  typedef logic [AW-1:0] addr_t;

  localparam word_t RESET_VAL = 16'h0000;

  // 2:1 bus multiplexer: sel=0 picks a, sel=1 picks b.
  function automatic word_t bus_mux2(input logic sel, input word_t a, input word_t b);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/reg_file_8x16_if.sv
// Register-file bus: one write port, two read ports, status outputs.
// Carries no state; read data arrives one cycle after the read request.
// No backpressure: every request is accepted on the edge it is presented.
interface reg_file_8x16_if;
  import reg_file_8x16_pkg::*;

  logic        we;
  addr_t       waddr;
  word_t       wdata;
  logic        re_a;
  addr_t       raddr_a;
  logic        re_b;
  addr_t       raddr_b;
  word_t       rdata_a;
  word_t       rdata_b;
  logic        valid_a;
  logic        valid_b;
  logic [7:0]  wr_count;

  modport master (
    output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    input  rdata_a, rdata_b, valid_a, valid_b, wr_count
  );

  modport slave (
    input  we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    output rdata_a, rdata_b, valid_a, valid_b, wr_count
  );

endinterface

// File: rtl/reg_file_8x16_reg16.sv
// W-bit storage register with load enable and asynchronous active-high reset.
// Latency: loads on the rising edge where en_i is high.
// No backpressure: holds its value whenever en_i is low.
module reg_file_8x16_reg16
  import reg_file_8x16_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en_i,
  input  word_t d_i,
  output word_t q_o
);

  word_t data_q;
  word_t data_d;

  // Next state: load new data when enabled, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (en_i) data_d = d_i;
  end

  // State register, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= RESET_VAL;
    else     data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_file_8x16.sv
// 8x16 register file with two registered read ports and write-to-read bypass.
// Latency: write visible to reads on the same edge via bypass; read data 1 cycle.
// No backpressure: all reads and writes complete on the edge they are presented.
module reg_file_8x16
  import reg_file_8x16_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  reg_file_8x16_if.slave bus
);

  logic [N-1:0] wen;
  word_t        regs_q [N];
  word_t        rd_a_d;
  word_t        rd_b_d;
  word_t        rdata_a_q;
  word_t        rdata_b_q;
  logic         valid_a_q;
  logic         valid_b_q;
  logic [7:0]   wr_count_q;
  logic [7:0]   wr_count_d;

  // 8:1 read multiplexer assembled as a three-level tree of 2:1 bus muxes.
  function automatic word_t mux8(input word_t r [N], input addr_t a);
    word_t l1 [4];
    word_t l2 [2];
    for (int k = 0; k < 4; k++) l1[k] = bus_mux2(a[0], r[2*k], r[2*k+1]);
    for (int k = 0; k < 2; k++) l2[k] = bus_mux2(a[1], l1[2*k], l1[2*k+1]);
    return bus_mux2(a[2], l2[0], l2[1]);
  endfunction

  // Write-address decoder: one-hot load enable for the addressed register.
  always_comb begin
    wen = '0;
    if (bus.we) wen[bus.waddr] = 1'b1;
  end

  for (genvar i = 0; i < N; i++) begin : g_store
    reg_file_8x16_reg16 u_reg (
      .clk  (clk),
      .rst  (reset),
      .en_i (wen[i]),
      .d_i  (bus.wdata),
      .q_o  (regs_q[i])
    );
  end

  // Read data selection; a same-edge write to the read address wins so a
  // dependent operation sees the fresh value without a stall.
  always_comb begin
    rd_a_d = mux8(regs_q, bus.raddr_a);
    rd_b_d = mux8(regs_q, bus.raddr_b);
    if (bus.we && (bus.raddr_a == bus.waddr)) rd_a_d = bus.wdata;
    if (bus.we && (bus.raddr_b == bus.waddr)) rd_b_d = bus.wdata;
  end

  reg_file_8x16_reg16 u_rd_a (
    .clk  (clk),
    .rst  (reset),
    .en_i (bus.re_a),
    .d_i  (rd_a_d),
    .q_o  (rdata_a_q)
  );

  reg_file_8x16_reg16 u_rd_b (
    .clk  (clk),
    .rst  (reset),
    .en_i (bus.re_b),
    .d_i  (rd_b_d),
    .q_o  (rdata_b_q)
  );

  // Committed-write counter next state; wraps naturally at 8 bits.
  always_comb begin
    wr_count_d = wr_count_q;
    if (bus.we) wr_count_d = wr_count_q + 8'd1;
  end

  // Valid flags follow the read enables by one edge; counter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_a_q  <= 1'b0;
      valid_b_q  <= 1'b0;
      wr_count_q <= 8'd0;
    end else begin
      valid_a_q  <= bus.re_a;
      valid_b_q  <= bus.re_b;
      wr_count_q <= wr_count_d;
    end
  end

  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;
  assign bus.valid_a  = valid_a_q;
  assign bus.valid_b  = valid_b_q;
  assign bus.wr_count = wr_count_q;

endmodule

// File: doc/reg_file_8x16.md
Name: reg_file_8x16

Overview:
- Eight-entry, 16-bit register file forming the write-back/operand stage of the lab datapath.
- The write port is fed by the 16-bit 2:1 bus multiplexer, which selects ALU result or load/immediate data.
- Two registered read ports supply operands A and B to the ALU input multiplexers.
- Provides write-to-read bypass so back-to-back dependent operations see fresh data without a stall.

Parameters:
- W, 16, data width in bits; bus bit ordering [0:W-1], matching the datapath buses.
- N, 8, number of registers.
- AW, 3, address width; must equal log2(N).

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  write enable; a write occurs at the clk edge when high.
- waddr  in  AW  write address.
- wdata  in  W [0:15]  write data, driven by the 2:1 16-bit bus multiplexer.
- re_a  in  1  read enable, port A.
- raddr_a  in  AW  read address, port A.
- re_b  in  1  read enable, port B.
- raddr_b  in  AW  read address, port B.
- rdata_a  out  W [0:15]  registered read data, port A.
- rdata_b  out  W [0:15]  registered read data, port B.
- valid_a  out  1  rdata_a was updated by a read on the previous edge.
- valid_b  out  1  rdata_b was updated by a read on the previous edge.
- wr_count  out  8  count of committed writes; wraps around.

Behaviour:
- Reset (asynchronous, active-high) applies immediately, independent of clk:
  - All N registers become 16'h0000.
  - rdata_a and rdata_b become 16'h0000.
  - valid_a, valid_b and wr_count become 0.
  - While reset is high, all writes and reads are ignored.
  - A reset asserted mid-operation discards any in-flight write or read. The first edge after deassertion behaves normally.
- Write path:
  - At a rising edge with we=1, reg[waddr] <= wdata.
  - wr_count increments by 1 modulo 256, so 255 -> 0.
  - With we=0, no register changes and wr_count holds.
- Read path (1-cycle latency, shown for port A; port B is identical and independent):
  - At a rising edge with re_a=1, rdata_a <= reg[raddr_a] and valid_a <= 1.
  - At a rising edge with re_a=0, rdata_a holds its previous value and valid_a <= 0.
- Bypass (read-during-write):
  - If we=1, re_a=1 and raddr_a==waddr at the same edge, rdata_a <= wdata (new data), not the old contents. Same rule for port B.
  - Both ports may read the same address in one cycle; both return identical data, including the bypass case.
- Conflicts and addressing:
  - Only one write port exists, so there are no write-write conflicts.
  - All addresses 0..N-1 are valid. There is no hardwired-zero register; reg0 is writable.
- Timing: no combinational path from any input to any output; all outputs come from flops.

Decomposition:
- Shared package/header holds the constants W=16, N=8, AW=3 and the reset value 16'h0000, so the ALU and multiplexer stages use the same widths.
- Sub-module reg16: W-bit register with enable and asynchronous active-high reset, instantiated N times for storage and twice for the read-data registers.
- Top level contains:
  - the write-address decoder (one-hot enable per reg16);
  - the 8:1 read multiplexers per port, built from the existing 2:1 bus mux;
  - the bypass compare logic;
  - the wr_count counter.

Test Plan:
- Reset check: pulse reset between clock edges -> all outputs 0 immediately. Then read every address on both ports -> 16'h0000 with valid=1, one cycle after each read.
- Write then read: write reg3=16'hA5C3, then next cycle re_a=1, raddr_a=3 -> rdata_a=16'hA5C3 and valid_a=1 one cycle later. rdata_b is unchanged while re_b=0.
- Bypass: reg5 holds 16'h1111. In the same cycle we=1, waddr=5, wdata=16'h2222 and re_a=re_b=1, raddr_a=raddr_b=5 -> both ports give 16'h2222. A following read of reg5 also gives 16'h2222.
- Hold/valid: read reg1=16'h00FF, then drop re_a for 3 cycles -> rdata_a stays 16'h00FF and valid_a=0 for those cycles.
- Counter wrap: perform 257 writes with we=1 -> wr_count ends at 1. Cycles with we=0 leave it unchanged.
- Reset mid-operation: assert reset asynchronously during a write of 16'hBEEF to reg7 -> reg7 reads 16'h0000 after release and wr_count=0.
